// File: rtl/key_search_ctrl.sv
// Multi-core key search controller: splits the key space across NUM_CORES cores, launches them,
// latches the first winning key and reports status, elapsed cycles and HEX display data.
module key_search_ctrl #(
   parameter int unsigned NUM_CORES = 4,
   parameter int unsigned KEY_W     = 24,
   parameter int unsigned KEY_SPACE = 24'h400000,
   parameter int unsigned CNT_W     = 32
) (
   input  logic                       CLK_50M,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic                       abort,
   input  logic [NUM_CORES-1:0]       core_found,
   input  logic [NUM_CORES-1:0]       core_done,
   input  logic [NUM_CORES*KEY_W-1:0] core_key,
   output logic                       core_start,
   output logic                       stop_all,
   output logic [NUM_CORES*KEY_W-1:0] core_low_key,
   output logic [NUM_CORES*KEY_W-1:0] core_high_key,
   output logic                       busy,
   output logic                       key_found,
   output logic                       key_not_found,
   output logic [3:0]                 winner,
   output logic [KEY_W-1:0]           secret_key,
   output logic [CNT_W-1:0]           elapsed,
   output logic [KEY_W-1:0]           hex_data
);

   typedef enum logic [2:0] {IDLE, LAUNCH, SEARCH, FOUND, EXHAUSTED} state_t;

   localparam int unsigned     SLICE   = KEY_SPACE / NUM_CORES;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t               state;
   logic [NUM_CORES-1:0] done_mask;
   logic [3:0]           win_idx;
   logic [KEY_W-1:0]     win_key;
   logic [KEY_W-5:0]     progress;

   // Last core takes the remainder of the integer division.
   for (genvar g = 0; g < NUM_CORES; g++) begin : g_part
      localparam int unsigned LO = g * SLICE;
      localparam int unsigned HI = (g == NUM_CORES - 1) ? KEY_SPACE : (g + 1) * SLICE;
      assign core_low_key[g*KEY_W +: KEY_W]  = KEY_W'(LO);
      assign core_high_key[g*KEY_W +: KEY_W] = KEY_W'(HI);
   end

   if (CNT_W >= KEY_W - 4) begin : g_prog_trunc
      assign progress = elapsed[KEY_W-5:0];
   end else begin : g_prog_ext
      assign progress = {{(KEY_W-4-CNT_W){1'b0}}, elapsed};
   end

   // Lowest-index core wins when several report in the same cycle.
   always_comb begin
      win_idx = '0;
      win_key = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (core_found[i]) begin
            win_idx = 4'(i);
            win_key = core_key[i*KEY_W +: KEY_W];
         end
      end
   end

   always_ff @(posedge CLK_50M or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         core_start    <= 1'b0;
         stop_all      <= 1'b0;
         busy          <= 1'b0;
         key_found     <= 1'b0;
         key_not_found <= 1'b0;
         winner        <= '0;
         secret_key    <= '0;
         elapsed       <= '0;
         done_mask     <= '0;
      end else begin
         core_start <= 1'b0;
         case (state)
            IDLE, FOUND, EXHAUSTED: begin
               // In IDLE, stop_all is only ever the one-cycle pulse left by an abort.
               if (state == IDLE) stop_all <= 1'b0;
               if (start) begin
                  state         <= LAUNCH;
                  core_start    <= 1'b1;
                  busy          <= 1'b1;
                  stop_all      <= 1'b0;
                  key_found     <= 1'b0;
                  key_not_found <= 1'b0;
                  winner        <= '0;
                  secret_key    <= '0;
                  elapsed       <= '0;
                  done_mask     <= '0;
               end
            end
            LAUNCH: state <= SEARCH;
            SEARCH: begin
               if (elapsed != CNT_MAX) elapsed <= elapsed + CNT_W'(1);
               done_mask <= done_mask | core_done;
               if (abort) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  stop_all <= 1'b1;
               end else if (|core_found) begin
                  state      <= FOUND;
                  busy       <= 1'b0;
                  stop_all   <= 1'b1;
                  key_found  <= 1'b1;
                  winner     <= win_idx;
                  secret_key <= win_key;
               end else if (&(done_mask | core_done)) begin
                  state         <= EXHAUSTED;
                  busy          <= 1'b0;
                  stop_all      <= 1'b1;
                  key_not_found <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      hex_data = '0;
      case (state)
         FOUND:     hex_data = secret_key;
         EXHAUSTED: hex_data = '1;
         SEARCH:    hex_data = {4'hF, progress};
         default:   hex_data = '0;
      endcase
   end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Bench for key_search_ctrl: directed and random searches, outcomes checked by a scoreboard monitor.
module tb_key_search_ctrl;
   localparam int KW = 24;
   localparam int K_FOUND = 0, K_NF = 1, K_ABORT = 2;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic           reset_n, start, abort;
   logic [3:0]     core_found, core_done;
   logic [4*KW-1:0] core_key;
   logic           core_start, stop_all, busy, key_found, key_not_found;
   logic [4*KW-1:0] low_key, high_key;
   logic [3:0]     winner;
   logic [KW-1:0]  secret_key, hex_data;
   logic [31:0]    elapsed;

   logic           start3, abort3;
   logic [2:0]     found3, done3;
   logic [3*KW-1:0] key3, low3, high3;
   logic           cs3, sa3, busy3, kf3, knf3;
   logic [3:0]     win3;
   logic [KW-1:0]  sk3, hx3;
   logic [31:0]    el3;

   key_search_ctrl dut (
      .CLK_50M(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .core_found(core_found), .core_done(core_done), .core_key(core_key),
      .core_start(core_start), .stop_all(stop_all), .core_low_key(low_key),
      .core_high_key(high_key), .busy(busy), .key_found(key_found),
      .key_not_found(key_not_found), .winner(winner), .secret_key(secret_key),
      .elapsed(elapsed), .hex_data(hex_data)
   );

   key_search_ctrl #(.NUM_CORES(3)) dut3 (
      .CLK_50M(clk), .reset_n(reset_n), .start(start3), .abort(abort3),
      .core_found(found3), .core_done(done3), .core_key(key3),
      .core_start(cs3), .stop_all(sa3), .core_low_key(low3),
      .core_high_key(high3), .busy(busy3), .key_found(kf3),
      .key_not_found(knf3), .winner(win3), .secret_key(sk3),
      .elapsed(el3), .hex_data(hx3)
   );

   typedef struct {
      int           kind;
      logic [3:0]   win;
      logic [KW-1:0] key;
      logic [31:0]  el;
      logic [KW-1:0] hex;
   } exp_t;

   exp_t sb[$];
   int   errors = 0, checks = 0;
   int   starts_exp = 0, starts_seen = 0;
   int   done_at[4];
   logic [KW-1:0] ev_key[4];
   bit   poke_start = 0;
   logic prev_busy = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: each time a search ends (busy falls) the oldest expected outcome is compared.
   always @(negedge clk) begin
      exp_t e;
      if (!reset_n) prev_busy = 1'b0;
      else begin
         if (core_start) starts_seen++;
         if (prev_busy && !busy) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_end: search ended with no outcome expected");
            end else begin
               e = sb.pop_front();
               chk("key_found", 64'(key_found), 64'(e.kind == K_FOUND));
               chk("key_not_found", 64'(key_not_found), 64'(e.kind == K_NF));
               chk("stop_all_end", 64'(stop_all), 64'd1);
               chk("winner", 64'(winner), 64'(e.win));
               chk("secret_key", 64'(secret_key), 64'(e.key));
               chk("elapsed_end", 64'(elapsed), 64'(e.el));
               chk("hex_end", 64'(hex_data), 64'(e.hex));
            end
         end
         prev_busy = busy;
      end
   end

   task automatic launch();
      start = 1'b1;
      tick();
      start = 1'b0;
      starts_exp++;
      chk("core_start_launch", 64'(core_start), 64'd1);
      chk("busy_launch", 64'(busy), 64'd1);
      chk("stop_all_launch", 64'(stop_all), 64'd0);
      chk("key_found_launch", 64'(key_found), 64'd0);
      chk("cleared_secret", 64'(secret_key), 64'd0);
      chk("cleared_winner", 64'(winner), 64'd0);
      chk("cleared_elapsed", 64'(elapsed), 64'd0);
      tick();
   endtask

   // One full search: outcome event lands in SEARCH cycle n.
   task automatic run(input int kind, input int n, input logic [3:0] fmask, input logic [3:0] extra);
      exp_t e;
      int w;
      launch();
      for (int k = 1; k <= n; k++) begin
         chk("elapsed_search", 64'(elapsed), 64'(k - 1));
         chk("hex_search", 64'(hex_data), 64'({4'hF, 20'(k - 1)}));
         chk("core_start_search", 64'(core_start), 64'd0);
         for (int c = 0; c < 4; c++) begin
            core_key[c*KW +: KW] = (k == n) ? ev_key[c] : KW'($urandom);
            core_done[c] = (done_at[c] == k);
         end
         start = poke_start && (k == 2);
         if (k == n) begin
            core_done = core_done | extra;
            core_found = (kind == K_NF) ? 4'b0 : fmask;
            abort = (kind == K_ABORT);
            e.kind = kind;
            e.win = '0;
            e.key = '0;
            e.el = 32'(n);
            e.hex = '0;
            if (kind == K_FOUND) begin
               w = 0;
               for (int c = 3; c >= 0; c--) if (fmask[c]) w = c;
               e.win = 4'(w);
               e.key = ev_key[w];
               e.hex = ev_key[w];
            end else if (kind == K_NF) begin
               e.hex = '1;
            end
            sb.push_back(e);
         end
         tick();
      end
      core_found = '0;
      core_done = '0;
      abort = 1'b0;
      start = 1'b0;
      if (kind == K_ABORT) begin
         chk("busy_after_abort", 64'(busy), 64'd0);
         tick();
         chk("stop_pulse_len", 64'(stop_all), 64'd0);
         chk("abort_no_found", 64'(key_found | key_not_found), 64'd0);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [KW-1:0] low4[4]  = '{24'h000000, 24'h100000, 24'h200000, 24'h300000};
      logic [KW-1:0] high4[4] = '{24'h100000, 24'h200000, 24'h300000, 24'h400000};
      logic [KW-1:0] lo3[3]   = '{24'h000000, 24'h155555, 24'h2AAAAA};
      logic [KW-1:0] hi3[3]   = '{24'h155555, 24'h2AAAAA, 24'h400000};
      int kind, n, h, r, budget;
      logic [3:0] fm, ex;

      reset_n = 1'b0;
      start = 1'b0; abort = 1'b0; core_found = '0; core_done = '0; core_key = '0;
      start3 = 1'b0; abort3 = 1'b0; found3 = '0; done3 = '0; key3 = '0;
      repeat (3) tick();
      chk("rst_status", 64'({core_start, stop_all, busy, key_found, key_not_found}), 64'd0);
      chk("rst_results", 64'({winner, secret_key, hex_data}), 64'd0);
      chk("rst_elapsed", 64'(elapsed), 64'd0);
      chk("rst3_status", 64'({cs3, sa3, busy3, kf3, knf3, win3}), 64'd0);
      chk("rst3_results", 64'({sk3, hx3}), 64'd0);
      chk("rst3_elapsed", 64'(el3), 64'd0);
      for (int c = 0; c < 4; c++) begin
         chk("low4", 64'(low_key[c*KW +: KW]), 64'(low4[c]));
         chk("high4", 64'(high_key[c*KW +: KW]), 64'(high4[c]));
      end
      for (int c = 0; c < 3; c++) begin
         chk("low3", 64'(low3[c*KW +: KW]), 64'(lo3[c]));
         chk("high3", 64'(high3[c*KW +: KW]), 64'(hi3[c]));
      end
      reset_n = 1'b1;
      tick();

      // Directed: core 2 finds 0AB123 in the tenth SEARCH cycle.
      done_at = '{0, 0, 0, 0};
      ev_key = '{24'h010101, 24'h020202, 24'h0AB123, 24'h040404};
      run(K_FOUND, 10, 4'b0100, 4'b0000);
      repeat (3) tick();
      chk("elapsed_frozen", 64'(elapsed), 64'd10);
      chk("found_hold", 64'({key_found, stop_all}), 64'b11);

      // Two finders at once; a later finder must not disturb the result.
      ev_key = '{24'h000000, 24'h111111, 24'h222222, 24'h333333};
      run(K_FOUND, 5, 4'b1010, 4'b0000);
      core_found = 4'b1000;
      core_key[3*KW +: KW] = 24'h777777;
      tick();
      core_found = '0;
      tick();
      chk("late_found_winner", 64'(winner), 64'd1);
      chk("late_found_key", 64'(secret_key), 64'h111111);
      chk("late_found_status", 64'(key_found), 64'd1);

      // Staggered done pulses: 0, then 3, then 1 and 2 together.
      done_at = '{2, 6, 6, 4};
      run(K_NF, 6, 4'b0000, 4'b0000);

      // Core 3 reports done and found together: found wins.
      done_at = '{1, 2, 3, 0};
      ev_key = '{24'h0, 24'h0, 24'h0, 24'hC0FFEE};
      run(K_FOUND, 4, 4'b1000, 4'b1000);

      // Abort with a simultaneous find, plus a stray start during SEARCH.
      done_at = '{0, 0, 0, 0};
      poke_start = 1;
      run(K_ABORT, 7, 4'b0001, 4'b1111);
      poke_start = 0;

      // Asynchronous reset in the middle of a search.
      launch();
      repeat (3) tick();
      reset_n = 1'b0;
      #1;
      chk("async_rst_status", 64'({core_start, stop_all, busy, key_found, key_not_found}), 64'd0);
      chk("async_rst_elapsed", 64'(elapsed), 64'd0);
      chk("async_rst_hex", 64'(hex_data), 64'd0);
      tick();
      reset_n = 1'b1;
      tick();

      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 2);
         n = $urandom_range(1, 15);
         fm = 4'($urandom_range(1, 15));
         ex = 4'($urandom_range(0, 15));
         for (int c = 0; c < 4; c++) ev_key[c] = KW'($urandom);
         if (kind == K_NF) begin
            r = $urandom_range(0, 3);
            for (int c = 0; c < 4; c++) done_at[c] = (c == r) ? n : $urandom_range(1, n);
            ex = '0;
         end else begin
            h = $urandom_range(0, 3);
            for (int c = 0; c < 4; c++) done_at[c] = (c == h) ? 0 : $urandom_range(0, n - 1);
         end
         poke_start = (n >= 3) && ($urandom_range(0, 1) == 1);
         run(kind, n, fm, ex);
         poke_start = 0;
         repeat ($urandom_range(0, 2)) tick();
      end

      budget = 0;
      while (sb.size() > 0 && budget < 20) begin
         tick();
         budget++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL outcome_timeout: %0d expected outcomes never seen", sb.size());
      end
      chk("core_start_count", 64'(starts_seen), 64'(starts_exp));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
